// File: rtl/dmux8way16_reg.sv
// rtl/dmux8way16_reg.sv - registered 8-way demux with per-channel valid/ready holding registers
// Optional: define DMUX8WAY16_COUNT_EN to add per-channel 8-bit input-transfer counters on COUNT.
module dmux8way16_reg #(
  parameter int WIDTH = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [WIDTH-1:0]   IN,
  input  logic [2:0]         S,
  input  logic               IN_VALID,
  output logic               IN_READY,
  output logic [8*WIDTH-1:0] OUT,
  output logic [7:0]         OUT_VALID,
  input  logic [7:0]         OUT_READY
`ifdef DMUX8WAY16_COUNT_EN
  ,
  output logic [63:0]        COUNT
`endif
);

  logic [8*WIDTH-1:0] data_q, data_d;
  logic [7:0]         valid_q, valid_d;
  logic               in_xfer;
  logic [7:0]         load;

  // Readiness looks only at the selected channel so words are never reordered.
  assign IN_READY = !RST && (!valid_q[S] || OUT_READY[S]);
  assign in_xfer  = IN_VALID && IN_READY;
  assign load     = in_xfer ? (8'b1 << S) : 8'b0;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    for (int k = 0; k < 8; k++) begin
      if (valid_q[k] && OUT_READY[k]) begin
        valid_d[k] = 1'b0;
      end
      // A load wins over a same-cycle drain: the new word replaces the old one.
      if (load[k]) begin
        data_d[k*WIDTH +: WIDTH] = IN;
        valid_d[k]               = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      data_q  <= '0;
      valid_q <= 8'h00;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign OUT       = data_q;
  assign OUT_VALID = valid_q;

`ifdef DMUX8WAY16_COUNT_EN
  logic [63:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    for (int k = 0; k < 8; k++) begin
      if (load[k]) begin
        count_d[k*8 +: 8] = count_q[k*8 +: 8] + 8'd1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign COUNT = count_q;
`endif

endmodule

// File: tb/tb_dmux8way16_reg.sv
// tb/tb_dmux8way16_reg.sv - directed self-checking bench for dmux8way16_reg
module tb_dmux8way16_reg;

  logic         CLK;
  logic         RST;
  logic [15:0]  IN;
  logic [2:0]   S;
  logic         IN_VALID;
  logic         IN_READY;
  logic [127:0] OUT;
  logic [7:0]   OUT_VALID;
  logic [7:0]   OUT_READY;
`ifdef DMUX8WAY16_COUNT_EN
  logic [63:0]  COUNT;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  dmux8way16_reg #(.WIDTH(16)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN        (IN),
    .S         (S),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .OUT       (OUT),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY)
`ifdef DMUX8WAY16_COUNT_EN
    ,
    .COUNT     (COUNT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [15:0] slice(input logic [127:0] v, input int k);
    return v[16*k +: 16];
  endfunction

  logic [15:0] walk_vec [8] = '{16'hF000, 16'h0F00, 16'h00F0, 16'h000F,
                                16'hA000, 16'h0A00, 16'h00A0, 16'h000A};

  initial begin
    RST = 1'b1; IN = '0; S = '0; IN_VALID = 1'b0; OUT_READY = 8'h00;
    step();
    step();
    check("rst_valid", 128'(OUT_VALID), 128'h0);
    check("rst_out", OUT, 128'h0);
    check("rst_in_ready", 128'(IN_READY), 128'h0);
    RST = 1'b0;
    #1;
    check("rel_in_ready", 128'(IN_READY), 128'h1);

    // Walk all selects with consumers always ready.
    OUT_READY = 8'hFF;
    IN_VALID  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      S  = 3'(i);
      IN = walk_vec[i];
      #1;
      check($sformatf("walk_ready_%0d", i), 128'(IN_READY), 128'h1);
      step();
      check($sformatf("walk_valid_%0d", i), 128'(OUT_VALID), 128'(8'b1 << i));
      check($sformatf("walk_data_%0d", i), 128'(slice(OUT, i)), 128'(walk_vec[i]));
    end
    IN_VALID = 1'b0;
    IN = 16'hDEAD; S = 3'd2;
    step();
    check("walk_drained", 128'(OUT_VALID), 128'h0);
    check("idle_no_effect", 128'(slice(OUT, 2)), 128'h00F0);

    // Backpressure on channel 3.
    OUT_READY = 8'h00;
    IN_VALID = 1'b1; S = 3'd3; IN = 16'h1234;
    #1;
    check("bp_ready_first", 128'(IN_READY), 128'h1);
    step();
    IN = 16'h5678;
    #1;
    check("bp_stalled", 128'(IN_READY), 128'h0);
    step();
    check("bp_hold_data", 128'(slice(OUT, 3)), 128'h1234);
    check("bp_hold_valid", 128'(OUT_VALID), 128'h08);
    OUT_READY = 8'h08;
    #1;
    check("bp_release_ready", 128'(IN_READY), 128'h1);
    step();
    check("bp_new_data", 128'(slice(OUT, 3)), 128'h5678);
    check("bp_new_valid", 128'(OUT_VALID), 128'h08);
    OUT_READY = 8'h00;
    IN_VALID = 1'b0;

    // Independence: channel 6 stalled does not block channel 1.
    IN_VALID = 1'b1; S = 3'd6; IN = 16'h6666;
    step();
    S = 3'd1; IN = 16'hBEEF;
    #1;
    check("ind_ready", 128'(IN_READY), 128'h1);
    step();
    check("ind_valid", 128'(OUT_VALID), 128'h4A);
    check("ind_ch1", 128'(slice(OUT, 1)), 128'hBEEF);
    check("ind_ch6", 128'(slice(OUT, 6)), 128'h6666);

    // Simultaneous drain and load on channel 4.
    S = 3'd4; IN = 16'h1111;
    step();
    check("sim_pre_valid", 128'(OUT_VALID), 128'h5A);
    OUT_READY = 8'h10; IN = 16'h2222;
    #1;
    check("sim_ready", 128'(IN_READY), 128'h1);
    step();
    check("sim_data", 128'(slice(OUT, 4)), 128'h2222);
    check("sim_valid", 128'(OUT_VALID), 128'h5A);
    IN_VALID = 1'b0;

    // Drain only: valid drops, data held.
    OUT_READY = 8'h02;
    step();
    check("drain_valid", 128'(OUT_VALID), 128'h58);
    check("drain_hold", 128'(slice(OUT, 1)), 128'hBEEF);
    OUT_READY = 8'h00;

    // Mid-run reset with channels 2 and 5 full.
    IN_VALID = 1'b1; S = 3'd2; IN = 16'h0202;
    step();
    S = 3'd5; IN = 16'h0505;
    step();
    check("pre_rst_valid", 128'(OUT_VALID), 128'h7C);
    S = 3'd0;
    RST = 1'b1;
    #1;
    check("mrst_valid", 128'(OUT_VALID), 128'h0);
    check("mrst_out", OUT, 128'h0);
    check("mrst_in_ready", 128'(IN_READY), 128'h0);
    step();
    check("mrst_hold_valid", 128'(OUT_VALID), 128'h0);
    IN_VALID = 1'b0;
    RST = 1'b0;
    #1;
    check("mrst_rel_ready", 128'(IN_READY), 128'h1);

`ifdef DMUX8WAY16_COUNT_EN
    check("cnt_reset", 128'(COUNT), 128'h0);
    OUT_READY = 8'hFF;
    IN_VALID = 1'b1; S = 3'd7;
    for (int i = 0; i < 257; i++) begin
      IN = 16'(i);
      step();
    end
    IN_VALID = 1'b0;
    step();
    check("cnt_wrap", 128'(COUNT), 128'(64'h0100_0000_0000_0000));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
